raizing_snd_mailbox: RTL and testbench

//  Parametrised main-CPU <-> sound-CPU mailbox. Replaces the fixed four soundlatch wires

---
 rtl/raizing_snd_mailbox.sv | 160 ++++++++++++++++
 tb/tb_raizing_snd_mailbox.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/raizing_snd_mailbox.sv
// 68K <-> Z80 sound mailbox: N command latches, M reply latches, pending/overrun flags, Z80 NMI pulse.
// Optional SNDMBOX_FIFO_EN turns command channel 0 into a FIFO of FIFO_DEPTH entries.
module raizing_snd_mailbox #(
  parameter int CMD_CH     = 4,
  parameter int RPL_CH     = 2,
  parameter int DW         = 8,
  parameter int NMI_CH     = 0,
  parameter int NMI_LEN    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              M_WR,
  input  logic [2:0]        M_WCH,
  input  logic [DW-1:0]     M_DIN,
  input  logic              M_RD,
  input  logic [2:0]        M_RCH,
  output logic [DW-1:0]     M_DOUT,
  output logic [RPL_CH-1:0] M_RPEND,
  input  logic              S_RD,
  input  logic [2:0]        S_RCH,
  output logic [DW-1:0]     S_DOUT,
  input  logic              S_WR,
  input  logic [2:0]        S_WCH,
  input  logic [DW-1:0]     S_DIN,
  output logic [CMD_CH-1:0] S_CPEND,
  output logic              NMI,
  output logic [CMD_CH-1:0] OVR
);

  localparam int CW = $clog2(NMI_LEN + 1);
`ifdef SNDMBOX_FIFO_EN
  localparam int FIRST = 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PONE = 1;
`else
  localparam int FIRST = 0;
`endif

  logic [DW-1:0]     cmd_q [CMD_CH];
  logic [DW-1:0]     cmd_d [CMD_CH];
  logic [CMD_CH-1:0] cpend_q, cpend_d, ovr_q, ovr_d;
  logic [DW-1:0]     sdout_q, sdout_d;
  logic [DW-1:0]     rpl_q [RPL_CH];
  logic [DW-1:0]     rpl_d [RPL_CH];
  logic [RPL_CH-1:0] rpend_q, rpend_d;
  logic [DW-1:0]     mdout_q, mdout_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CMD_CH-1:0] cwr, crd;
  logic [RPL_CH-1:0] rwr, rrd;
  logic              nmi_wr;

`ifdef SNDMBOX_FIFO_EN
  logic [DW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          f_empty, f_full, f_wr, f_rd;

  assign f_empty = (wptr_q == rptr_q);
  assign f_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A read in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign f_wr    = cwr[0] && (!f_full || crd[0]);
  assign f_rd    = crd[0] && !f_empty;

  always_ff @(posedge CLK) begin
    if (f_wr) fifo_mem_q[wptr_q[AW-1:0]] <= M_DIN;
  end
`endif

  always_comb begin
    cwr = '0;
    crd = '0;
    rwr = '0;
    rrd = '0;
    for (int c = 0; c < CMD_CH; c++) begin
      cwr[c] = M_WR && (M_WCH == 3'(c));
      crd[c] = S_RD && (S_RCH == 3'(c));
    end
    for (int r = 0; r < RPL_CH; r++) begin
      rwr[r] = S_WR && (S_WCH == 3'(r));
      rrd[r] = M_RD && (M_RCH == 3'(r));
    end
    nmi_wr = (NMI_CH < CMD_CH) && M_WR && (M_WCH == 3'(NMI_CH));
  end

  always_comb begin
    cmd_d   = cmd_q;
    cpend_d = cpend_q;
    ovr_d   = ovr_q;
    sdout_d = sdout_q;
    for (int c = FIRST; c < CMD_CH; c++) begin
      if (crd[c]) sdout_d = cmd_q[c];
      if (cwr[c]) cmd_d[c] = M_DIN;
      if (cwr[c])      cpend_d[c] = 1'b1;
      else if (crd[c]) cpend_d[c] = 1'b0;
      // A read in the same cycle consumes the old value, so the overwrite is not lost data.
      if (crd[c])                     ovr_d[c] = 1'b0;
      else if (cwr[c] && cpend_q[c])  ovr_d[c] = 1'b1;
    end
`ifdef SNDMBOX_FIFO_EN
    wptr_d = f_wr ? wptr_q + PONE : wptr_q;
    rptr_d = f_rd ? rptr_q + PONE : rptr_q;
    if (crd[0]) sdout_d = f_empty ? {DW{1'b1}} : fifo_mem_q[rptr_q[AW-1:0]];
    cpend_d[0] = (wptr_d != rptr_d);
    if (wptr_d == rptr_d)                    ovr_d[0] = 1'b0;
    else if (cwr[0] && f_full && !crd[0])    ovr_d[0] = 1'b1;
`endif

    rpl_d   = rpl_q;
    rpend_d = rpend_q;
    mdout_d = mdout_q;
    for (int r = 0; r < RPL_CH; r++) begin
      if (rrd[r]) mdout_d = rpl_q[r];
      if (rwr[r]) rpl_d[r] = S_DIN;
      if (rwr[r])      rpend_d[r] = 1'b1;
      else if (rrd[r]) rpend_d[r] = 1'b0;
    end

    if (nmi_wr)            cnt_d = CW'(NMI_LEN);
    else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
    else                   cnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < CMD_CH; c++) cmd_q[c] <= '0;
      for (int r = 0; r < RPL_CH; r++) rpl_q[r] <= '0;
      cpend_q <= '0;
      ovr_q   <= '0;
      sdout_q <= '0;
      rpend_q <= '0;
      mdout_q <= '0;
      cnt_q   <= '0;
`ifdef SNDMBOX_FIFO_EN
      wptr_q  <= '0;
      rptr_q  <= '0;
`endif
    end else begin
      cmd_q   <= cmd_d;
      rpl_q   <= rpl_d;
      cpend_q <= cpend_d;
      ovr_q   <= ovr_d;
      sdout_q <= sdout_d;
      rpend_q <= rpend_d;
      mdout_q <= mdout_d;
      cnt_q   <= cnt_d;
`ifdef SNDMBOX_FIFO_EN
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
`endif
    end
  end

  assign S_DOUT  = sdout_q;
  assign M_DOUT  = mdout_q;
  assign S_CPEND = cpend_q;
  assign M_RPEND = rpend_q;
  assign OVR     = ovr_q;
  assign NMI     = (cnt_q != '0);

endmodule

// File: tb/tb_raizing_snd_mailbox.sv
// Scoreboard bench for raizing_snd_mailbox: expected read data is queued at issue and popped one cycle later.
module tb_raizing_snd_mailbox;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       M_WR = 1'b0, M_RD = 1'b0, S_RD = 1'b0, S_WR = 1'b0;
  logic [2:0] M_WCH = '0, M_RCH = '0, S_RCH = '0, S_WCH = '0;
  logic [7:0] M_DIN = '0, S_DIN = '0;
  logic [7:0] M_DOUT, S_DOUT;
  logic [1:0] M_RPEND;
  logic [3:0] S_CPEND, OVR;
  logic       NMI;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  raizing_snd_mailbox dut (
    .CLK(CLK), .RESET(RESET),
    .M_WR(M_WR), .M_WCH(M_WCH), .M_DIN(M_DIN), .M_RD(M_RD), .M_RCH(M_RCH),
    .M_DOUT(M_DOUT), .M_RPEND(M_RPEND),
    .S_RD(S_RD), .S_RCH(S_RCH), .S_DOUT(S_DOUT), .S_WR(S_WR), .S_WCH(S_WCH),
    .S_DIN(S_DIN), .S_CPEND(S_CPEND), .NMI(NMI), .OVR(OVR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mwr(input logic [2:0] ch, input logic [7:0] d);
    M_WR = 1'b1; M_WCH = ch; M_DIN = d;
    tick();
    M_WR = 1'b0;
  endtask

  task automatic swr(input logic [2:0] ch, input logic [7:0] d);
    S_WR = 1'b1; S_WCH = ch; S_DIN = d;
    tick();
    S_WR = 1'b0;
  endtask

  task automatic sread(input logic [2:0] ch, input logic [7:0] expv);
    exp_q.push_back(expv);
    S_RD = 1'b1; S_RCH = ch;
    tick();
    S_RD = 1'b0;
  endtask

  task automatic mread(input logic [2:0] ch, input logic [7:0] expv);
    exp_q.push_back(expv);
    M_RD = 1'b1; M_RCH = ch;
    tick();
    M_RD = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({NMI, S_CPEND, OVR, M_RPEND} !== 11'd0 || S_DOUT !== 8'h00 || M_DOUT !== 8'h00) begin
      errors++; $display("FAIL reset_init: nmi=%b cpend=%b ovr=%b rpend=%b sdout=%h mdout=%h required all zero", NMI, S_CPEND, OVR, M_RPEND, S_DOUT, M_DOUT);
    end
    tick();
    RESET = 1'b0;
    tick();
    mwr(3'd1, 8'hAB);
    sread(3'd1, 8'hAB);
    e = exp_q.pop_front();
    checks++; if (S_DOUT !== e) begin errors++; $display("FAIL reset_pre_read: got %h need %h", S_DOUT, e); end
    mwr(3'd2, 8'h10);
    mwr(3'd2, 8'h20);
    swr(3'd0, 8'h99);
    mwr(3'd0, 8'h01);
    checks++; if (NMI !== 1'b1 || OVR[2] !== 1'b1 || S_CPEND[2] !== 1'b1 || M_RPEND !== 2'b01) begin
      errors++; $display("FAIL reset_pre_state: nmi=%b ovr=%b cpend=%b rpend=%b need nmi=1 ovr[2]=1 cpend[2]=1 rpend=01", NMI, OVR, S_CPEND, M_RPEND);
    end
    tick();
    tick();
    RESET = 1'b1;
    #1;
    checks++; if (NMI !== 1'b0 || S_CPEND !== 4'd0 || OVR !== 4'd0 || M_RPEND !== 2'd0 || S_DOUT !== 8'h00) begin
      errors++; $display("FAIL reset_mid_nmi: nmi=%b cpend=%b ovr=%b rpend=%b sdout=%h need all zero", NMI, S_CPEND, OVR, M_RPEND, S_DOUT);
    end
    tick();
    RESET = 1'b0;
    tick();
    tick();
    checks++; if (NMI !== 1'b0) begin errors++; $display("FAIL reset_nmi_idle: nmi=%b need 0", NMI); end
  endtask

  task automatic test_cmd_read();
    mwr(3'd2, 8'h5A);
    checks++; if (S_CPEND[2] !== 1'b1) begin errors++; $display("FAIL cmd_pend_set: got %b need 1", S_CPEND[2]); end
    sread(3'd2, 8'h5A);
    e = exp_q.pop_front();
    checks++; if (S_DOUT !== e || S_CPEND[2] !== 1'b0) begin
      errors++; $display("FAIL cmd_read: sdout=%h pend=%b need %h pend=0", S_DOUT, S_CPEND[2], e);
    end
    tick();
    checks++; if (S_DOUT !== 8'h5A) begin errors++; $display("FAIL cmd_hold: got %h need 5a", S_DOUT); end
  endtask

  task automatic test_overrun();
    mwr(3'd1, 8'h11);
    checks++; if (OVR[1] !== 1'b0) begin errors++; $display("FAIL ovr_first_write: got %b need 0", OVR[1]); end
    mwr(3'd1, 8'h22);
    checks++; if (OVR[1] !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b need 1", OVR[1]); end
    sread(3'd1, 8'h22);
    e = exp_q.pop_front();
    checks++; if (S_DOUT !== e || OVR[1] !== 1'b0 || S_CPEND[1] !== 1'b0) begin
      errors++; $display("FAIL ovr_read: sdout=%h ovr=%b pend=%b need %h ovr=0 pend=0", S_DOUT, OVR[1], S_CPEND[1], e);
    end
  endtask

  task automatic test_same_cycle();
    mwr(3'd3, 8'h33);
    exp_q.push_back(8'h33);
    M_WR = 1'b1; M_WCH = 3'd3; M_DIN = 8'h77;
    S_RD = 1'b1; S_RCH = 3'd3;
    tick();
    M_WR = 1'b0; S_RD = 1'b0;
    e = exp_q.pop_front();
    checks++; if (S_DOUT !== e || S_CPEND[3] !== 1'b1 || OVR[3] !== 1'b0) begin
      errors++; $display("FAIL same_cycle: sdout=%h pend=%b ovr=%b need %h pend=1 ovr=0", S_DOUT, S_CPEND[3], OVR[3], e);
    end
    sread(3'd3, 8'h77);
    e = exp_q.pop_front();
    checks++; if (S_DOUT !== e || S_CPEND[3] !== 1'b0) begin
      errors++; $display("FAIL same_cycle_next: sdout=%h pend=%b need %h pend=0", S_DOUT, S_CPEND[3], e);
    end
  endtask

  task automatic test_reply();
    swr(3'd1, 8'hC3);
    checks++; if (M_RPEND !== 2'b10) begin errors++; $display("FAIL rpl_pend: got %b need 10", M_RPEND); end
    mread(3'd1, 8'hC3);
    e = exp_q.pop_front();
    checks++; if (M_DOUT !== e || M_RPEND !== 2'b00) begin
      errors++; $display("FAIL rpl_read: mdout=%h pend=%b need %h pend=00", M_DOUT, M_RPEND, e);
    end
    swr(3'd0, 8'h01);
    exp_q.push_back(8'h01);
    S_WR = 1'b1; S_WCH = 3'd0; S_DIN = 8'h02;
    M_RD = 1'b1; M_RCH = 3'd0;
    tick();
    S_WR = 1'b0; M_RD = 1'b0;
    e = exp_q.pop_front();
    checks++; if (M_DOUT !== e || M_RPEND[0] !== 1'b1) begin
      errors++; $display("FAIL rpl_same_cycle: mdout=%h pend=%b need %h pend=1", M_DOUT, M_RPEND[0], e);
    end
    mread(3'd0, 8'h02);
    e = exp_q.pop_front();
    checks++; if (M_DOUT !== e || M_RPEND !== 2'b00) begin
      errors++; $display("FAIL rpl_next: mdout=%h pend=%b need %h", M_DOUT, M_RPEND, e);
    end
  endtask

  task automatic test_ignore();
    mwr(3'd5, 8'hEE);
    swr(3'd3, 8'hDD);
    checks++; if (S_CPEND !== 4'd0 || OVR !== 4'd0 || M_RPEND !== 2'd0 || NMI !== 1'b0) begin
      errors++; $display("FAIL ignore_write: cpend=%b ovr=%b rpend=%b nmi=%b need zeros", S_CPEND, OVR, M_RPEND, NMI);
    end
    sread(3'd7, 8'h77);
    mread(3'd6, 8'h02);
    e = exp_q.pop_front();
    checks++; if (S_DOUT !== e) begin errors++; $display("FAIL ignore_sread: got %h need %h", S_DOUT, e); end
    e = exp_q.pop_front();
    checks++; if (M_DOUT !== e) begin errors++; $display("FAIL ignore_mread: got %h need %h", M_DOUT, e); end
  endtask

  task automatic test_nmi();
    int high_cnt;
    int first_low;
    int late_high;
    high_cnt = 0; first_low = -1; late_high = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 0 || k == 5) begin M_WR = 1'b1; M_WCH = 3'd0; M_DIN = 8'(k); end
      tick();
      M_WR = 1'b0;
      if (NMI === 1'b1) begin
        high_cnt++;
        if (first_low >= 0) late_high++;
      end else if (first_low < 0) begin
        first_low = k;
      end
    end
    checks++; if (high_cnt != 13 || first_low != 13 || late_high != 0) begin
      errors++; $display("FAIL nmi_retrigger: high=%0d first_low=%0d late=%0d need 13 13 0", high_cnt, first_low, late_high);
    end
  endtask

`ifdef SNDMBOX_FIFO_EN
  task automatic test_fifo();
    do_reset();
    for (int i = 0; i < 17; i++) mwr(3'd0, 8'(i));
    checks++; if (OVR[0] !== 1'b1 || S_CPEND[0] !== 1'b1) begin
      errors++; $display("FAIL fifo_full: ovr=%b pend=%b need 1 1", OVR[0], S_CPEND[0]);
    end
    for (int i = 0; i < 17; i++) begin
      sread(3'd0, (i < 16) ? 8'(i) : 8'hFF);
      e = exp_q.pop_front();
      checks++; if (S_DOUT !== e) begin errors++; $display("FAIL fifo_read%0d: got %h need %h", i, S_DOUT, e); end
    end
    checks++; if (S_CPEND[0] !== 1'b0 || OVR[0] !== 1'b0) begin
      errors++; $display("FAIL fifo_empty: pend=%b ovr=%b need 0 0", S_CPEND[0], OVR[0]);
    end
    exp_q.push_back(8'hFF);
    M_WR = 1'b1; M_WCH = 3'd0; M_DIN = 8'h42;
    S_RD = 1'b1; S_RCH = 3'd0;
    tick();
    M_WR = 1'b0; S_RD = 1'b0;
    e = exp_q.pop_front();
    checks++; if (S_DOUT !== e || S_CPEND[0] !== 1'b1) begin
      errors++; $display("FAIL fifo_rw_empty: sdout=%h pend=%b need %h pend=1", S_DOUT, S_CPEND[0], e);
    end
    sread(3'd0, 8'h42);
    e = exp_q.pop_front();
    checks++; if (S_DOUT !== e || S_CPEND[0] !== 1'b0) begin
      errors++; $display("FAIL fifo_rw_next: sdout=%h pend=%b need %h", S_DOUT, S_CPEND[0], e);
    end
  endtask
`else
  task automatic test_ch0_latch();
    do_reset();
    mwr(3'd0, 8'h44);
    mwr(3'd0, 8'h45);
    checks++; if (S_CPEND[0] !== 1'b1 || OVR[0] !== 1'b1) begin
      errors++; $display("FAIL ch0_ovr: pend=%b ovr=%b need 1 1", S_CPEND[0], OVR[0]);
    end
    sread(3'd0, 8'h45);
    e = exp_q.pop_front();
    checks++; if (S_DOUT !== e || S_CPEND[0] !== 1'b0 || OVR[0] !== 1'b0) begin
      errors++; $display("FAIL ch0_read: sdout=%h pend=%b ovr=%b need %h 0 0", S_DOUT, S_CPEND[0], OVR[0], e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cmd_read();
    test_overrun();
    test_same_cycle();
    test_reply();
    test_ignore();
    test_nmi();
`ifdef SNDMBOX_FIFO_EN
    test_fifo();
`else
    test_ch0_latch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
